uio_bus_arb: RTL
================

UIO_BUS_ARB -- requirements
Module: uio_bus_arb

Interface
REQ-001 The block SHALL have parameter BURST, default 4, meaning the maximum consecutive grant cycles while the other requester waits (legal range 1..15).
REQ-002 The block SHALL have parameter TURN_CYC, default 1, meaning bus-released cycles inserted on every direction change (legal range 1..7).
REQ-003 The block SHALL use one clock with synchronous active-low reset; the ports SHALL be named clk and rst_n.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 req_tx  in  1  transmit requester wants to drive the uio bus.
REQ-007 tx_data  in  8  data driven on the bus while transmit is granted.
REQ-008 gnt_tx  out  1  transmit owns the bus this cycle.
REQ-009 req_rx  in  1  receive requester wants to sample the uio bus.
REQ-010 gnt_rx  out  1  receive owns the bus this cycle.
REQ-011 rx_data  out  8  last sampled bus value.
REQ-012 rx_valid  out  1  one-cycle strobe: rx_data updated.
REQ-013 uio_in  in  8  pad input path.
REQ-014 uio_out  out  8  pad output path.
REQ-015 uio_oe  out  8  pad enables, 1 = output.
REQ-016 busy  out  1  state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, DRIVE, SAMPLE and TURN; gnt_tx=1 only in DRIVE, gnt_rx=1 only in SAMPLE, and busy=(state!=IDLE).
REQ-018 uio_oe SHALL be 8'hFF in DRIVE and 8'h00 in every other state.
REQ-019 uio_out SHALL equal tx_data in DRIVE in the same cycle, and 8'h00 otherwise.
REQ-020 IDLE SHALL move to DRIVE if only req_tx is asserted, and to SAMPLE if only req_rx is asserted; the grant appears one cycle after the request is sampled, with no TURN.
REQ-021 When both requesters are asserted in IDLE, the side not served last SHALL win; after reset, TX SHALL win the first tie.
REQ-022 A 4-bit grant counter SHALL clear on entry to DRIVE or SAMPLE, increment on every granted cycle, and saturate at BURST.
REQ-023 In DRIVE or SAMPLE with the owner still requesting, the FSM SHALL go to TURN when the counter equals BURST and the other side requests; otherwise it SHALL stay.
REQ-024 When the owner drops its request, the FSM SHALL go to TURN if the other side requests, else to IDLE, with no grant in the next cycle.
REQ-025 TURN SHALL last exactly TURN_CYC cycles with no grant; it then enters the opposite direction if that requester is asserted, else IDLE.
REQ-026 A direction change (DRIVE to SAMPLE, or SAMPLE to DRIVE) SHALL always pass through TURN; entry from IDLE SHALL never use TURN.
REQ-027 Each SAMPLE cycle SHALL register uio_in into rx_data and assert rx_valid in the following cycle only; rx_data SHALL otherwise hold its value.
REQ-028 The last-served flag SHALL update on every entry to DRIVE or SAMPLE.

Reset
REQ-029 While rst_n=0 at a rising clk edge, the block SHALL enter IDLE, clear both counters and rx_data (8'h00) and rx_valid, and set last-served to RX; outputs SHALL read gnt_tx=0, gnt_rx=0, uio_oe=8'h00, uio_out=8'h00 and busy=0 from that edge.
REQ-030 A reset asserted mid-DRIVE, mid-SAMPLE or mid-TURN SHALL abort with no further grant or rx_valid; no turnaround SHALL be owed after reset.

Structure
REQ-031 The package uio_arb_pkg SHALL hold the state enumeration and the default BURST and TURN_CYC constants.
REQ-032 A single sub-module, uio_arb_timer, SHALL implement the shared clear/increment/compare counter used for both burst and turnaround counting.

Verification
REQ-033 Verification SHALL cover: req_tx=1 only, tx_data=8'hA5 -> gnt_tx and uio_oe=8'hFF one cycle later, and uio_out=8'hA5.
REQ-034 Verification SHALL cover: both requests asserted from reset -> DRIVE for 4 cycles, TURN for 1 cycle with uio_oe=8'h00, then SAMPLE for 4 cycles, TURN, then DRIVE.
REQ-035 Verification SHALL cover: SAMPLE with uio_in=8'h3C -> rx_data=8'h3C and a single-cycle rx_valid on the next cycle.
REQ-036 Verification SHALL cover: TURN_CYC=3, req_rx dropped during TURN -> 3 cycles with no grant, then IDLE, then DRIVE if req_tx is still asserted.
REQ-037 Verification SHALL cover: rst_n=0 during DRIVE -> uio_oe=8'h00 and gnt_tx=0 after the next edge, and the first tie after reset goes to TX.
REQ-038 Verification SHALL cover: req_tx alone held for 20 cycles -> continuous DRIVE with the counter saturated at 4 and no TURN.

Source files
------------

// File: rtl/uio_arb_pkg.sv
// rtl/uio_arb_pkg.sv - shared constants and state encoding for the uio bus arbiter
package uio_arb_pkg;

   localparam int unsigned BURST_DEF    = 4;
   localparam int unsigned TURN_CYC_DEF = 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DRIVE  = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_TURN   = 2'd3;

   localparam logic SIDE_RX = 1'b0;
   localparam logic SIDE_TX = 1'b1;

endpackage

// File: rtl/uio_arb_timer.sv
// rtl/uio_arb_timer.sv - saturating cycle counter shared by burst and turnaround timing
module uio_arb_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       inc_i,
   input  logic [3:0] max_i,
   output logic       hit_o
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 4'd0;
      end else if (inc_i && (cnt_q != max_i)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Counts the current cycle too, so the limit is reached one count early.
   assign hit_o = (cnt_q >= (max_i - 4'd1));

endmodule

// File: rtl/uio_bus_arb.sv
// rtl/uio_bus_arb.sv - two-requester arbiter for a bidirectional uio pad bus
module uio_bus_arb
   import uio_arb_pkg::*;
#(
   parameter int unsigned BURST    = BURST_DEF,
   parameter int unsigned TURN_CYC = TURN_CYC_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_tx,
   input  logic [7:0] tx_data,
   output logic       gnt_tx,
   input  logic       req_rx,
   output logic       gnt_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic       busy
);

   localparam logic [3:0] BURST_L = 4'(BURST);
   localparam logic [3:0] TURN_L  = 4'(TURN_CYC);

   logic [1:0] state_q, state_d;
   logic       last_q, last_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       own_req, oth_req;
   logic       tmr_hit;

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      rx_valid_d = (state_q == ST_SAMPLE);
      rx_data_d  = (state_q == ST_SAMPLE) ? uio_in : rx_data_q;
      own_req    = (state_q == ST_DRIVE) ? req_tx : req_rx;
      oth_req    = (state_q == ST_DRIVE) ? req_rx : req_tx;
      case (state_q)
         ST_IDLE: begin
            if (req_tx && (!req_rx || (last_q == SIDE_RX))) begin
               state_d = ST_DRIVE;
            end else if (req_rx) begin
               state_d = ST_SAMPLE;
            end
         end
         ST_DRIVE, ST_SAMPLE: begin
            if (!own_req) begin
               state_d = oth_req ? ST_TURN : ST_IDLE;
            end else if (oth_req && tmr_hit) begin
               state_d = ST_TURN;
            end
         end
         ST_TURN: begin
            // last_q still names the side that held the bus before the turn.
            if (tmr_hit) begin
               if (last_q == SIDE_TX) begin
                  state_d = req_rx ? ST_SAMPLE : ST_IDLE;
               end else begin
                  state_d = req_tx ? ST_DRIVE : ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if ((state_d != state_q) && (state_d == ST_DRIVE)) begin
         last_d = SIDE_TX;
      end else if ((state_d != state_q) && (state_d == ST_SAMPLE)) begin
         last_d = SIDE_RX;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         last_q     <= SIDE_RX;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   uio_arb_timer u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (state_d != state_q),
      .inc_i (state_q != ST_IDLE),
      .max_i ((state_q == ST_TURN) ? TURN_L : BURST_L),
      .hit_o (tmr_hit)
   );

   assign gnt_tx   = (state_q == ST_DRIVE);
   assign gnt_rx   = (state_q == ST_SAMPLE);
   assign busy     = (state_q != ST_IDLE);
   assign uio_oe   = (state_q == ST_DRIVE) ? 8'hFF : 8'h00;
   assign uio_out  = (state_q == ST_DRIVE) ? tx_data : 8'h00;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

endmodule
